truth_table_checker: RTL and testbench

Response-side counterpart to the exhaustive stimulus benches used for combinational lab gates. It accepts (input vector, observed output) pairs from a stimulus source and compares each observed output against a parameterised truth table. It also tracks which of the 2^N_IN vectors have been exercised and reports a pass/fail verdict once coverage is complete. It is synthesizable, so it can sit on the board next to the device under test and drive LEDs in place of a simulator `$display`.

---
 rtl/truth_table_checker.sv | 95 +++++++++
 tb/tb_truth_table_checker.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// Response checker for exhaustive combinational-gate benches: compares observed
// outputs against a truth table, tracks vector coverage and latches a verdict.
module truth_table_checker #(
  parameter int                    N_IN  = 3,
  parameter logic [(1<<N_IN)-1:0]  TRUTH = 8'b1000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 vec_valid,
  input  logic [N_IN-1:0]      vec,
  input  logic                 obs,
  output logic                 ready,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [(1<<N_IN)-1:0] seen,
  output logic                 first_fail_valid,
  output logic [N_IN-1:0]      first_fail_vec
);

  localparam int NV = 1 << N_IN;

  // Handshake: a pair transfers on any cycle where vec_valid && ready && !start.
  // ready is high only in RUN; start in the same cycle wins and drops the pair.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NV-1:0]     seen_q;
  logic [N_IN:0]     err_q;
  logic              ff_valid_q;
  logic [N_IN-1:0]   ff_vec_q;

  logic              accept;
  logic              mismatch;
  logic [NV-1:0]     vec_bit;

  assign vec_bit  = {{(NV-1){1'b0}}, 1'b1} << vec;
  assign accept   = (state_q == RUN) && vec_valid && !start;
  assign mismatch = (obs != TRUTH[vec]);

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (accept && (&(seen_q | vec_bit))) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q     <= '0;
      err_q      <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
    end else if (start) begin
      seen_q     <= '0;
      err_q      <= '0;
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
    end else if (accept) begin
      seen_q <= seen_q | vec_bit;
      if (mismatch) begin
        // Saturate rather than wrap so a long bad run never reads as clean.
        if (err_q != '1) err_q <= err_q + {{N_IN{1'b0}}, 1'b1};
        if (!ff_valid_q) begin
          ff_valid_q <= 1'b1;
          ff_vec_q   <= vec;
        end
      end
    end
  end

  assign ready            = (state_q == RUN);
  assign done             = (state_q == DONE);
  assign pass             = (state_q == DONE) && (err_q == '0);
  assign err_count        = err_q;
  assign seen             = seen_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed plus random bench for truth_table_checker using the default 3-input AND table.
module tb_truth_table_checker;

  localparam int N_IN = 3;
  localparam int NV   = 8;
  localparam int W    = 3 + (N_IN + 1) + NV + 1 + N_IN;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              vec_valid;
  logic [N_IN-1:0]   vec;
  logic              obs;
  logic              ready;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [NV-1:0]     seen;
  logic              first_fail_valid;
  logic [N_IN-1:0]   first_fail_vec;

  truth_table_checker #(.N_IN(N_IN), .TRUTH(8'b1000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec(vec), .obs(obs),
    .ready(ready), .done(done), .pass(pass), .err_count(err_count), .seen(seen),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0]    exp_q[$];
  int              n_assert = 0;
  int              n_fail   = 0;
  logic [NV-1:0]   tt;
  int              m_state;
  logic [NV-1:0]   m_seen;
  logic [N_IN:0]   m_err;
  logic            m_ffv;
  logic [N_IN-1:0] m_ffvec;

  function automatic logic [W-1:0] model_pack();
    logic r, d, p;
    r = (m_state == 1);
    d = (m_state == 2);
    p = d && (m_err == 0);
    return {r, d, p, m_err, m_seen, m_ffv, m_ffvec};
  endfunction

  function automatic logic [W-1:0] dut_pack();
    return {ready, done, pass, err_count, seen, first_fail_valid, first_fail_vec};
  endfunction

  task automatic model_reset();
    m_state = 0; m_seen = '0; m_err = '0; m_ffv = 1'b0; m_ffvec = '0;
  endtask

  task automatic model_update(input logic s, input logic v, input logic [N_IN-1:0] x, input logic o);
    if (s) begin
      model_reset();
      m_state = 1;
    end else if (m_state == 1 && v) begin
      if (o != tt[x]) begin
        if (m_err != 4'd15) m_err = m_err + 4'd1;
        if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = x; end
      end
      m_seen[x] = 1'b1;
      if (m_seen == 8'hFF) m_state = 2;
    end
  endtask

  task automatic check(input string tag);
    logic [W-1:0] e, g;
    e = exp_q.pop_front();
    g = dut_pack();
    n_assert++;
    assert (g === e) else begin
      n_fail++;
      $error("FAIL %s: observed {rdy,done,pass,err,seen,ffv,ffvec}=%h expected %h", tag, g, e);
    end
  endtask

  // driver: apply one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic s, input logic v, input logic [N_IN-1:0] x, input logic o, input string tag);
    @(negedge clk);
    start = s; vec_valid = v; vec = x; obs = o;
    model_update(s, v, x, o);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    start = 1'b0; vec_valid = 1'b0;
    check(tag);
  endtask

  task automatic run_in_order(input logic [NV-1:0] flip, input string tag);
    for (int i = 0; i < NV; i++) begin
      logic [N_IN-1:0] x;
      x = N_IN'(i);
      step(1'b0, 1'b1, x, tt[x] ^ flip[x], tag);
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    exp_q.push_back(model_pack());
    #1 check(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [N_IN-1:0] order [9];
    tt = 8'b1000_0000;
    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec = '0; obs = 1'b0;
    model_reset();
    #12;
    exp_q.push_back(model_pack());
    check("reset_values");
    rst_n = 1'b1;

    // vec_valid in IDLE is ignored
    step(1'b0, 1'b1, 3'd0, 1'b1, "idle_ignore");

    // clean in-order run
    step(1'b1, 1'b0, 3'd0, 1'b0, "start_clean");
    run_in_order(8'h00, "clean_run");
    step(1'b0, 1'b1, 3'd2, 1'b1, "done_ignore");
    step(1'b0, 1'b0, 3'd0, 1'b0, "done_hold");

    // two mismatches, first at vec 5; start issued from DONE
    step(1'b1, 1'b0, 3'd0, 1'b0, "start_from_done");
    run_in_order(8'b1010_0000, "two_mismatch");

    // out-of-order with a duplicate
    order = '{3'd7, 3'd3, 3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    step(1'b1, 1'b0, 3'd0, 1'b0, "start_ooo");
    foreach (order[i]) step(1'b0, 1'b1, order[i], tt[order[i]], "ooo_dup");

    // restart mid-run; the pair coincident with start is dropped
    step(1'b1, 1'b0, 3'd0, 1'b0, "start_mid");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, N_IN'(i), 1'b1, "pre_restart");
    step(1'b1, 1'b1, 3'd6, 1'b1, "restart_drop");
    step(1'b0, 1'b0, 3'd0, 1'b0, "bubble");
    run_in_order(8'h00, "after_restart");

    // saturation on repeated mismatches at vec 0
    step(1'b1, 1'b0, 3'd0, 1'b0, "start_sat");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 3'd0, 1'b1, "saturate");

    // random run with bubbles and occasional wrong observations
    step(1'b1, 1'b0, 3'd0, 1'b0, "start_rand");
    for (int i = 0; i < 300 && m_state != 2; i++) begin
      logic [N_IN-1:0] x;
      x = N_IN'($urandom_range(0, NV - 1));
      step(1'b0, 1'($urandom_range(0, 3) != 0), x,
           tt[x] ^ 1'($urandom_range(0, 5) == 0), "random");
    end
    n_assert++;
    assert (done === 1'b1) else begin
      n_fail++;
      $error("FAIL random_timeout: observed done=%b expected 1", done);
    end

    // async reset in DONE, then vec_valid ignored until start
    pulse_reset("async_reset");
    step(1'b0, 1'b1, 3'd7, 1'b0, "post_reset_ignore");
    step(1'b1, 1'b0, 3'd0, 1'b0, "post_reset_start");
    step(1'b0, 1'b1, 3'd7, 1'b0, "post_reset_accept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
